// File: rtl/soc_system_buttons_debounce.sv
// Push-button debouncer: two-flop synchroniser plus a per-bit stability counter in front of the PIO in_port.
// Optional edge pulses are built only when SOC_BUTTONS_DEBOUNCE_EDGE_PULSE_EN is defined.
module soc_system_buttons_debounce #(
    parameter int                 WIDTH         = 4,
    parameter int                 STABLE_CYCLES = 1000000,
    parameter int                 CNT_W         = 20,
    parameter logic [WIDTH-1:0]   RESET_VAL     = {WIDTH{1'b1}}
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] btn_raw_i,
    output logic [WIDTH-1:0] btn_db_o,
    output logic [WIDTH-1:0] rise_pulse_o,
    output logic [WIDTH-1:0] fall_pulse_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] sync0_q;
    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] db_q;
    logic [WIDTH-1:0] db_d;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sync0_q <= RESET_VAL;
            sync1_q <= RESET_VAL;
            db_q    <= RESET_VAL;
        end else begin
            sync0_q <= btn_raw_i;
            sync1_q <= sync0_q;
            db_q    <= db_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_bit
            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;
            logic             bit_d;

            // Any agreement with the current output restarts the count from zero.
            always_comb begin
                cnt_d = cnt_q;
                bit_d = db_q[gi];
                if (sync1_q[gi] == db_q[gi]) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    bit_d = sync1_q[gi];
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            always_ff @(posedge clk_i or posedge reset_i) begin
                if (reset_i) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign db_d[gi] = bit_d;
        end
    endgenerate

    assign btn_db_o = db_q;

`ifdef SOC_BUTTONS_DEBOUNCE_EDGE_PULSE_EN
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] fall_q;

    // Pulses are derived from the next-state value so they line up with the btn_db change.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            rise_q <= db_d & ~db_q;
            fall_q <= ~db_d & db_q;
        end
    end

    assign rise_pulse_o = rise_q;
    assign fall_pulse_o = fall_q;
`else
    assign rise_pulse_o = '0;
    assign fall_pulse_o = '0;
`endif

endmodule
